mem_port_arbiter: RTL and testbench

- Shares one single-ported synchronous memory between two requesters: instruction fetch (IF) and data memory access (DM).
- Sits between the CPU-side port pair and the unified memory, in place of a pure DM passthrough.
- Grants at most one requester per cycle, routes read data back one cycle later, and bounds IF starvation with a counter.

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 71 +++++++
 tb/tb_mem_port_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/read-return and unified-memory signals shared by the arbiter
// and its environment; the arbiter takes the slave side.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic [31:0] dm_pc;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_we;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic [31:0] mem_pc;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_we;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_pc, dm_addr, dm_wdata, dm_we, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_pc, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output if_req, if_addr, dm_req, dm_pc, dm_addr, dm_wdata, dm_we, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_pc, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / DM) arbiter for one single-ported synchronous memory.
// DM has priority; IF is forced through after STARVE_LIMIT consecutive DM wins.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_DM = 2'd2} owner_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt_q, starve_cnt_d;
   owner_e     rd_owner_q, rd_owner_d;
   logic       force_if, if_gnt, dm_gnt;

   assign force_if = (starve_cnt_q == LIMIT);
   assign if_gnt   = bus.if_req & (~bus.dm_req | force_if);
   assign dm_gnt   = bus.dm_req & ~if_gnt;

   assign bus.if_gnt = if_gnt;
   assign bus.dm_gnt = dm_gnt;

   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_we    = '0;
      bus.mem_pc    = '0;
      if (dm_gnt) begin
         bus.mem_addr  = bus.dm_addr;
         bus.mem_wdata = bus.dm_wdata;
         bus.mem_we    = bus.dm_we;
         bus.mem_pc    = bus.dm_pc;
      end else if (if_gnt) begin
         bus.mem_addr  = bus.if_addr;
      end
   end

   // Counter only tracks DM wins while IF is actually waiting.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (if_gnt || !bus.if_req)
         starve_cnt_d = '0;
      else if (dm_gnt && starve_cnt_q != LIMIT)
         starve_cnt_d = starve_cnt_q + 4'd1;
   end

   always_comb begin
      rd_owner_d = OWN_NONE;
      if (if_gnt)
         rd_owner_d = OWN_IF;
      else if (dm_gnt && bus.dm_we == 4'd0)
         rd_owner_d = OWN_DM;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt_q <= '0;
         rd_owner_q   <= OWN_NONE;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   assign bus.if_rvalid = (rd_owner_q == OWN_IF);
   assign bus.dm_rvalid = (rd_owner_q == OWN_DM);
   assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
   assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: grants and mem_* checked each cycle against a reference
// arbiter; read returns queued at grant and compared the following cycle.
module tb_mem_port_arbiter;
   localparam int unsigned LIM = 4;
   localparam logic [1:0] E_NONE = 2'd0, E_IF = 2'd1, E_DM = 2'd2;

   typedef struct {
      logic [1:0]  own;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory contents as seen by the DUT, and the bench's independent copy
   logic [31:0] mem_arr [256];
   logic [31:0] ref_mem [256];
   exp_t        sb [$];
   logic [3:0]  mcnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      return (i == 0) ? 32'h2408_0005 : (32'hA500_0000 | (i * 32'h0001_0203));
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = init_word(i);
         ref_mem[i] = init_word(i);
      end
   end

   // synchronous memory: write at end of cycle, read data one cycle later
   always @(posedge clk) begin
      if (bus.mem_we != 4'd0)
         mem_arr[bus.mem_addr[9:2]] <= merge(mem_arr[bus.mem_addr[9:2]], bus.mem_wdata, bus.mem_we);
      bus.mem_rdata <= mem_arr[bus.mem_addr[9:2]];
   end

   always @(negedge clk) begin : mon
      exp_t        e;
      exp_t        n;
      logic        eif, edm;
      logic [31:0] ea, ewd, epc;
      logic [3:0]  ewe;
      e = '{own: E_NONE, data: 32'h0};
      if (sb.size() > 0) e = sb.pop_front();
      if (!reset) e = '{own: E_NONE, data: 32'h0};
      chk("if_rvalid", 32'(bus.if_rvalid), 32'(e.own == E_IF));
      chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(e.own == E_DM));
      chk("if_rdata", bus.if_rdata, (e.own == E_IF) ? e.data : 32'h0);
      chk("dm_rdata", bus.dm_rdata, (e.own == E_DM) ? e.data : 32'h0);
      chk("starve_cnt", 32'(dut.starve_cnt_q), 32'(mcnt));
      if (!reset) begin
         sb.delete();
         sb.push_back('{own: E_NONE, data: 32'h0});
         mcnt = 4'd0;
      end else begin
         eif = bus.if_req && (!bus.dm_req || mcnt == 4'(LIM));
         edm = bus.dm_req && !eif;
         ea = 32'h0; ewd = 32'h0; epc = 32'h0; ewe = 4'h0;
         if (edm) begin
            ea = bus.dm_addr; ewd = bus.dm_wdata; ewe = bus.dm_we; epc = bus.dm_pc;
         end else if (eif) begin
            ea = bus.if_addr;
         end
         chk("if_gnt", 32'(bus.if_gnt), 32'(eif));
         chk("dm_gnt", 32'(bus.dm_gnt), 32'(edm));
         chk("mem_addr", bus.mem_addr, ea);
         chk("mem_wdata", bus.mem_wdata, ewd);
         chk("mem_we", 32'(bus.mem_we), 32'(ewe));
         chk("mem_pc", bus.mem_pc, epc);
         n = '{own: E_NONE, data: 32'h0};
         if (eif) n = '{own: E_IF, data: ref_mem[bus.if_addr[9:2]]};
         else if (edm && bus.dm_we == 4'd0) n = '{own: E_DM, data: ref_mem[bus.dm_addr[9:2]]};
         sb.push_back(n);
         if (edm && bus.dm_we != 4'd0)
            ref_mem[bus.dm_addr[9:2]] = merge(ref_mem[bus.dm_addr[9:2]], bus.dm_wdata, bus.dm_we);
         if (eif || !bus.if_req) mcnt = 4'd0;
         else if (edm && mcnt != 4'(LIM)) mcnt = mcnt + 4'd1;
      end
   end

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [31:0] da, input logic [31:0] wd,
                        input logic [3:0] we, input logic [31:0] pc);
      bus.if_req = ir; bus.if_addr = ia;
      bus.dm_req = dr; bus.dm_addr = da; bus.dm_wdata = wd; bus.dm_we = we; bus.dm_pc = pc;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
   endtask

   initial begin
      mcnt = 4'd0;
      reset = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0; bus.dm_addr = '0;
      bus.dm_wdata = '0; bus.dm_we = '0; bus.dm_pc = '0;
      idle(2);
      reset = 1'b1;
      idle(2);
      // IF alone
      drive(1'b1, 32'h3000, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      idle(1);
      // DM full write, then read it back
      drive(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h3004);
      idle(1);
      drive(1'b0, 32'h0, 1'b1, 32'h10, 32'h0, 4'h0, 32'h3008);
      // partial write then read
      drive(1'b0, 32'h0, 1'b1, 32'h24, 32'h1234_5678, 4'b0011, 32'h300C);
      drive(1'b0, 32'h0, 1'b1, 32'h24, 32'h0, 4'h0, 32'h3010);
      idle(1);
      // contention: DM x4, IF, DM
      for (int i = 0; i < 6; i++) drive(1'b1, 32'h3008, 1'b1, 32'h20, 32'h0, 4'h0, 32'h3014);
      idle(1);
      // interleaved DM then IF reads
      drive(1'b0, 32'h0, 1'b1, 32'h20, 32'h0, 4'h0, 32'h3018);
      drive(1'b1, 32'h3008, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      idle(1);
      // reset between a DM read grant and its return
      drive(1'b0, 32'h0, 1'b1, 32'h20, 32'h0, 4'h0, 32'h301C);
      reset = 1'b0;
      idle(1);
      reset = 1'b1;
      idle(1);
      drive(1'b1, 32'h3000, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      idle(1);
      // random mix
      for (int i = 0; i < 60; i++) begin
         logic [3:0] we;
         case ($urandom_range(0, 3))
            0, 1:    we = 4'h0;
            2:       we = 4'hF;
            default: we = 4'(($urandom_range(1, 14)));
         endcase
         drive(1'($urandom_range(0, 1)), {22'h0, 8'($urandom_range(0, 255)), 2'b00},
               1'($urandom_range(0, 1)), {22'h0, 8'($urandom_range(0, 15)), 2'b00},
               $urandom, we, $urandom);
      end
      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
